// File: rtl/tcs3200_emulator.sv
// tcs3200_emulator: light-to-frequency colour sensor stand-in; define TCS_EMU_JITTER_EN to add 0-3 cycles of LFSR jitter per half-period
module tcs3200_emulator #(
  parameter int SETTLE_CYCLES = 8,
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      s,
  input  logic            oe,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [HP_W-1:0] wr_data,
  output logic            out,
  output logic            settling
);
  localparam int EW = HP_W + 6;
  localparam int CW = EW + 1;
  typedef enum logic [1:0] {SETTLE, HIGH, LOW, IDLE} state_t;
  state_t state, state_n;
  logic [3:0] s_m, s_q, s_p;
  logic [HP_W-1:0] hp [4];
  logic [1:0] ch, jit;
  logic [5:0] mult;
  logic [EW-1:0] eff;
  logic [CW-1:0] cnt, cnt_n, phase;
  logic chg, enter;
  assign ch = s_q[3:2] == 2'b00 ? 2'd0 : s_q[3:2] == 2'b10 ? 2'd2 : s_q[3:2] == 2'b01 ? 2'd3 : 2'd1;
  assign mult = s_q[1:0] == 2'b10 ? 6'd50 : s_q[1:0] == 2'b01 ? 6'd5 : s_q[1:0] == 2'b11 ? 6'd1 : 6'd0;
  assign eff = EW'(hp[ch]) * EW'(mult);
  assign phase = CW'(eff) + CW'(jit);
  assign chg = s_q != s_p;
  assign enter = (state_n == HIGH || state_n == LOW) && state_n != state;
`ifdef TCS_EMU_JITTER_EN
  logic [15:0] lfsr;
  assign jit = lfsr[1:0];
  // advance the jitter source once per half-period entry
  always_ff @(posedge clk)
    if (!rst) lfsr <= 16'hACE1;
    else if (enter) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`else
  assign jit = 2'd0;
`endif
  // next state: select change forces a settle; power-down shows up as eff==0
  always_comb begin
    state_n = state;
    cnt_n = cnt - CW'(1);
    if (chg) begin
      state_n = SETTLE;
      cnt_n = CW'(SETTLE_CYCLES);
    end else if (state == IDLE || cnt == CW'(1)) begin
      state_n = eff == '0 ? IDLE : state == HIGH ? LOW : HIGH;
      cnt_n = eff == '0 ? cnt : phase;
    end
  end
  // select synchroniser and half-period register file
  always_ff @(posedge clk)
    if (!rst) begin
      s_m <= '0;
      s_q <= '0;
      s_p <= '0;
      hp <= '{default: '0};
    end else begin
      s_m <= s;
      s_q <= s_m;
      s_p <= s_q;
      if (wr_en) hp[wr_sel] <= wr_data;
    end
  // state, phase counter and registered outputs with oe gating
  always_ff @(posedge clk)
    if (!rst) begin
      state <= SETTLE;
      cnt <= CW'(SETTLE_CYCLES);
      out <= 1'b0;
      settling <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out <= !oe && state_n == HIGH;
      settling <= state_n == SETTLE;
    end
endmodule

// File: tb/tb_tcs3200_emulator.sv
// tb_tcs3200_emulator: scoreboard bench for the colour sensor emulator
module tb_tcs3200_emulator;
  logic clk = 0, rst = 0, oe = 1, wr_en = 0;
  logic [3:0] s = '0;
  logic [1:0] wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic out, settling;
  int total = 0, bad = 0;
  int q[$];

  tcs3200_emulator dut (
    .clk(clk), .rst(rst), .s(s), .oe(oe), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_data(wr_data), .out(out), .settling(settling)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write(input logic [1:0] c, input int v);
    wr_sel = c;
    wr_data = 16'(v);
    wr_en = 1;
    tick();
    wr_en = 0;
  endtask

  task automatic push(input int v, input int n);
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  task automatic wait_rise(input string tag, input int exp, input int exp_set);
    int n, st;
    logic prev;
    bit seen;
    n = 0; st = 0; prev = out; seen = 0;
    while (n < 3000 && !seen) begin
      tick();
      n++;
      if (settling) st++;
      if (out && !prev) seen = 1;
      prev = out;
    end
    check(tag, seen ? n : -1, exp);
    if (exp_set >= 0) check({tag, "_settle"}, st, exp_set);
  endtask

  task automatic phases(input int n);
    for (int i = 0; i < n; i++) begin
      int len, exp;
      logic lvl;
      len = 0;
      lvl = out;
      do begin
        tick();
        len++;
      end while (out == lvl && len < 5000);
      exp = q.size() > 0 ? q.pop_front() : -1;
      check("phase", len, exp);
    end
  endtask

  task automatic count_high(input string tag, input int n);
    int hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (out) hi++;
    end
    check(tag, hi, 0);
  endtask

  initial begin
    int mism, drop;
    tick(); tick(); tick();
    check("reset_out", int'(out), 0);
    check("reset_settling", int'(settling), 1);
    rst = 1;
    repeat (20) tick();
    check("idle_settling", int'(settling), 0);
    oe = 0;
    write(2'd0, 10);
    s = 4'b0011;
    wait_rise("first_rise", 11, 8);
    push(10, 6);
    phases(6);

    s = 4'b0010;
    wait_rise("rise_2pct", 11, 8);
    push(500, 2);
    phases(2);
    s = 4'b0001;
    wait_rise("rise_20pct", 11, 8);
    push(50, 4);
    phases(4);

    write(2'd1, 4);
    write(2'd2, 7);
    s = 4'b1011;
    wait_rise("rise_blue", 11, 8);
    push(7, 2);
    phases(2);
    tick(); tick();
    s = 4'b1111;
    drop = 0;
    do begin
      tick();
      drop++;
    end while (out && drop < 20);
    check("switch_drop", drop, 3);
    wait_rise("rise_green", 8, 7);
    push(4, 4);
    phases(4);
    s = 4'b1011;
    repeat (4) tick();
    s = 4'b1111;
    wait_rise("settle_restart", 11, 10);
    push(4, 4);
    phases(4);

    tick();
    oe = 1;
    count_high("oe_gate", 15);
    oe = 0;
    mism = 0;
    for (int t = 17; t <= 32; t++) begin
      tick();
      if (out !== ((t / 4) % 2 == 0)) mism++;
    end
    check("oe_resume", mism, 0);

    s = 4'b0111;
    repeat (20) tick();
    count_high("clear_zero", 20);
    check("clear_zero_settling", int'(settling), 0);
    write(2'd3, 3);
    wait_rise("clear_start", 1, -1);
    push(3, 4);
    phases(4);
    s = 4'b0100;
    tick(); tick(); tick();
    count_high("power_down", 100);

    s = 4'b0011;
    wait_rise("red_again", 11, 8);
    push(10, 1);
    phases(1);
    tick(); tick(); tick();
    rst = 0;
    tick();
    check("midreset_out", int'(out), 0);
    check("midreset_settling", int'(settling), 1);
    tick();
    rst = 1;
    count_high("after_reset", 40);
    write(2'd0, 10);
    wait_rise("red_rewrite", 1, -1);
    push(10, 2);
    phases(2);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tcs3200_emulator.md
# tcs3200_emulator

Behavioural stand-in for a TCS3200-class light-to-frequency colour sensor, synthesisable for on-board loopback tests of the colour-sensor reader. It accepts the reader's filter/scaling selects (S0–S3) and active-low output enable, and produces the sensor's `out` square wave whose half-period is programmed per colour channel through a simple write port. This allows full closed-loop testing without optics.

## Interface
- `SETTLE_CYCLES`, 8: cycles `out` is held low after any change of the filter or scaling select.
- `HP_W`, 16: width of the per-channel half-period registers.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `s`  in  4  selects. `s[0]`=S0 and `s[1]`=S1 are scaling; `s[2]`=S2 and `s[3]`=S3 are filter.
- `oe`  in  1  output enable, active-low.
- `wr_en`  in  1  write strobe for a channel half-period register.
- `wr_sel`  in  2  channel select: 00 red, 01 green, 10 blue, 11 clear.
- `wr_data`  in  HP_W  half-period value, in clk cycles at 100 % scaling.
- `out`  out  1  emulated sensor frequency output, registered.
- `settling`  out  1  high while in the settle hold.

## Operation
- **Select synchroniser:** `s` passes through a 2-flop synchroniser; the FSM uses the synchronised value `s_q`.
- **Filter mapping, `{S2,S3}`:** 00 red, 01 blue, 10 clear, 11 green. So `s[3:2]`=00 red, 10 blue, 01 clear, 11 green.
- **Scaling, `s[1:0]`:**
  - 00: power-down; `out`=0 and the counter stops.
  - 10 (2 %): multiplier 50.
  - 01 (20 %): multiplier 5.
  - 11 (100 %): multiplier 1.
- **Effective half-period:** `eff` = `hp[channel]` × multiplier, computed at HP_W+6 bits with no truncation.
- **FSM states:** `SETTLE`, `HIGH`, `LOW`, `IDLE`.
  - `SETTLE`: `out`=0, `settling`=1, count down SETTLE_CYCLES, then go to `HIGH`. If `eff`=0 or power-down, go to `IDLE` instead.
  - `HIGH` / `LOW`: `out`=1 / 0 for exactly `eff` cycles, then toggle to the other state. `eff` is sampled at each phase entry. A register write therefore takes effect at the next half-period boundary and never mid-phase.
  - `IDLE`: `out`=0. Re-evaluate every cycle; enter `HIGH` once `eff`≠0 and scaling≠00.
- **Select change:** any change of `s_q[3:0]` (filter or scaling) from the previous cycle forces `SETTLE` from any state. The settle counter reloads, so a change during `SETTLE` restarts the hold.
- **Output enable:** `oe`=1 gates `out` to 0 only. The FSM and counters keep running, so deasserting `oe` resumes mid-phase with no settle.
- **Register writes:** `wr_en` writes `wr_data` to the selected channel the same cycle. Writing the active channel does not trigger a settle.

## Timing
- **Reset values:** `out`=0, `settling`=1, state `SETTLE`, settle counter = SETTLE_CYCLES, all `hp` registers 0, synchroniser 0.
- **Reset mid-operation:** returns to exactly these values on the next edge.
- **Select-change latency:** a select change at input edge N appears in `s_q` at N+2. The FSM enters `SETTLE` at N+3 (`out`=0, `settling`=1). The first `out` rising edge is at N+3+SETTLE_CYCLES.
- **Output period:** 2×`eff` cycles, 50 % duty (exact without the jitter option).
- **`oe` path:** gating is registered, 1-cycle latency.
- **Counter widths:** sized so that `eff` max = (2^HP_W−1)×50 never wraps.

## Configuration
- `TCS_EMU_JITTER_EN` defined: a 16-bit LFSR (seed 0xACE1, reset-loaded, advanced once per phase entry) adds 0–3 extra cycles to each half-period, using its low 2 bits. This exercises the reader's averaging.
- Undefined: no LFSR; half-periods are exactly `eff`.
- All test-plan values assume undefined.

## Test plan
- **Basic waveform:** reset; write red=10; `s`=4'b0011, `oe`=0 → `settling` for 8 cycles, then `out` period 20 (10 high / 10 low), first rise 11 cycles after `s` stable.
- **2 % scaling:** red=10, `s`=4'b0010 → period 1000 cycles. `s`=4'b0001 (20 %) → settle, then period 100.
- **Filter switch:** green=4, blue=7; switch `s[3:2]` 10→11 mid-`HIGH` → `out` low within 3 cycles, `settling` high 8 cycles, then period 8. Changing `s` again during `SETTLE` restarts the 8-cycle hold.
- **Output enable:** `oe`=1 for 15 cycles mid-wave → `out`=0 throughout. After release, `out` continues at the phase it would have had; no settle.
- **Zero / power-down:** clear=0, `s`=4'b0111 → `out` held 0 (`IDLE`). Write clear=3 → `out` starts 6-cycle period. `s[1:0]`=00 → `out`=0 indefinitely.
- **Reset mid-operation:** assert `rst`=0 mid-`LOW` with red=10 → next edge `out`=0, `settling`=1, registers cleared. After release, `out` stays 0 until red is rewritten.
